// File: rtl/writeback_unit.sv
`default_nettype none
// writeback_unit: buffers executor results in a small FIFO and retires one entry per cycle
// to the register file, resolving port/PC write conflicts. Rev 1.0
module writeback_unit #(
  parameter int BIT_WIDTH    = 32,
  parameter int REG_COUNT_L2 = 4,
  parameter int NUM_WR_PORTS = 2,
  parameter int DEPTH        = 4,
  parameter int PC_INDEX     = 15,
  parameter int AUTO_INC     = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [BIT_WIDTH-1:0]                 in_pc,
  input  logic                                 in_update_pc,
  input  logic [BIT_WIDTH-1:0]                 in_new_pc,
  input  logic [NUM_WR_PORTS-1:0]              in_wr_en,
  input  logic [NUM_WR_PORTS*REG_COUNT_L2-1:0] in_wr_addr,
  input  logic [NUM_WR_PORTS*BIT_WIDTH-1:0]    in_wr_value,
  input  logic                                 stall,
  input  logic                                 flush,
  output logic [NUM_WR_PORTS-1:0]              regfile_write_enable,
  output logic [NUM_WR_PORTS*REG_COUNT_L2-1:0] regfile_write_addr,
  output logic [NUM_WR_PORTS*BIT_WIDTH-1:0]    regfile_write_value,
  output logic                                 regfile_update_pc,
  output logic [BIT_WIDTH-1:0]                 regfile_new_pc,
  output logic [31:0]                          retired_count,
  output logic                                 conflict_error,
  output logic                                 empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [REG_COUNT_L2-1:0] PC_ADDR    = REG_COUNT_L2'(PC_INDEX);
  localparam logic [CW-1:0]           FULL_COUNT = CW'(DEPTH);

  logic [BIT_WIDTH-1:0]                 fifo_pc     [DEPTH];
  logic                                 fifo_upd    [DEPTH];
  logic [BIT_WIDTH-1:0]                 fifo_new_pc [DEPTH];
  logic [NUM_WR_PORTS-1:0]              fifo_en     [DEPTH];
  logic [NUM_WR_PORTS*REG_COUNT_L2-1:0] fifo_addr   [DEPTH];
  logic [NUM_WR_PORTS*BIT_WIDTH-1:0]    fifo_value  [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign pop      = !empty && !stall && !flush;
  assign in_ready = !reset && !flush && (!full || pop);
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]     <= in_pc;
      fifo_upd[wr_ptr]    <= in_update_pc;
      fifo_new_pc[wr_ptr] <= in_new_pc;
      fifo_en[wr_ptr]     <= in_wr_en;
      fifo_addr[wr_ptr]   <= in_wr_addr;
      fifo_value[wr_ptr]  <= in_wr_value;
    end
  end

  logic [NUM_WR_PORTS*REG_COUNT_L2-1:0] head_addr;
  logic [NUM_WR_PORTS-1:0]              head_en, en_next;
  logic                                 head_upd, pc_target, conflict_next, upd_next;
  logic [BIT_WIDTH-1:0]                 new_pc_next;

  assign head_addr = fifo_addr[rd_ptr];
  assign head_en   = fifo_en[rd_ptr];
  assign head_upd  = fifo_upd[rd_ptr];

  always_comb begin
    en_next       = head_en;
    pc_target     = 1'b0;
    conflict_next = 1'b0;
    for (int i = 0; i < NUM_WR_PORTS; i++) begin
      if (head_en[i] && head_addr[i*REG_COUNT_L2 +: REG_COUNT_L2] == PC_ADDR) begin
        pc_target = 1'b1;
        if (head_upd) begin
          en_next[i]    = 1'b0;
          conflict_next = 1'b1;
        end
      end
      // Lower-numbered port wins a same-address collision.
      for (int j = 0; j < NUM_WR_PORTS; j++) begin
        if (j < i && head_en[j] && head_en[i] &&
            head_addr[j*REG_COUNT_L2 +: REG_COUNT_L2] == head_addr[i*REG_COUNT_L2 +: REG_COUNT_L2]) begin
          en_next[i]    = 1'b0;
          conflict_next = 1'b1;
        end
      end
    end
    upd_next    = 1'b0;
    new_pc_next = fifo_new_pc[rd_ptr];
    if (head_upd) begin
      upd_next = 1'b1;
    end else if (AUTO_INC == 1 && !pc_target) begin
      upd_next    = 1'b1;
      new_pc_next = fifo_pc[rd_ptr] + BIT_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regfile_write_enable <= '0;
      regfile_write_addr   <= '0;
      regfile_write_value  <= '0;
      regfile_update_pc    <= 1'b0;
      regfile_new_pc       <= '0;
      retired_count        <= '0;
      conflict_error       <= 1'b0;
    end else if (pop) begin
      regfile_write_enable <= en_next;
      regfile_write_addr   <= head_addr;
      regfile_write_value  <= fifo_value[rd_ptr];
      regfile_update_pc    <= upd_next;
      regfile_new_pc       <= new_pc_next;
      retired_count        <= retired_count + 32'd1;
      if (conflict_next) conflict_error <= 1'b1;
    end else begin
      regfile_write_enable <= '0;
      regfile_update_pc    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, datapath/PC width.
REQ-002 SHALL have parameter REG_COUNT_L2, default 4, register address width.
REQ-003 SHALL have parameter NUM_WR_PORTS, default 2, regfile write ports per entry (1..4).
REQ-004 SHALL have parameter DEPTH, default 4, buffer entries (power of 2, >=2).
REQ-005 SHALL have parameter PC_INDEX, default 15, register index aliased to PC.
REQ-006 SHALL have parameter AUTO_INC, default 1, 1 = PC advances by 4 when no explicit PC update.
REQ-007 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous active-high reset.
REQ-008 SHALL have ports: in_valid  in  1 / in_ready  out  1  executor handshake.
REQ-009 SHALL have ports: in_pc  in  BIT_WIDTH; in_update_pc  in  1; in_new_pc  in  BIT_WIDTH.
REQ-010 SHALL have ports: in_wr_en  in  NUM_WR_PORTS; in_wr_addr  in  NUM_WR_PORTS*REG_COUNT_L2; in_wr_value  in  NUM_WR_PORTS*BIT_WIDTH (port i at slice i).
REQ-011 SHALL have ports: stall  in  1 (hold commit); flush  in  1 (discard buffered entries).
REQ-012 SHALL have ports: regfile_write_enable / _addr / _value  out  NUM_WR_PORTS / NUM_WR_PORTS*REG_COUNT_L2 / NUM_WR_PORTS*BIT_WIDTH.
REQ-013 SHALL have ports: regfile_update_pc  out  1; regfile_new_pc  out  BIT_WIDTH.
REQ-014 SHALL have ports: retired_count  out  32; conflict_error  out  1 (sticky); empty  out  1.

Function
REQ-015 SHALL accept an entry when in_valid && in_ready at a rising edge; in_ready = !full || pop-this-cycle.
REQ-016 SHALL buffer entries in a DEPTH-deep circular FIFO; pointers wrap modulo DEPTH; full/empty from a DEPTH+1-range occupancy count.
REQ-017 SHALL pop the head when !empty && !stall && !flush; simultaneous push and pop on full SHALL keep occupancy unchanged.
REQ-018 SHALL register all regfile_* outputs: a popped entry drives them for exactly one cycle, the cycle after the pop edge; otherwise all enables/update_pc are 0.
REQ-019 SHALL give minimum latency 1 cycle: entry accepted into empty buffer at edge t is popped at edge t+1, outputs valid in cycle after t+1 (bypass not permitted).
REQ-020 SHALL, per port i, set regfile_write_enable[i] = wr_en[i], passing addr/value unchanged.
REQ-021 SHALL, when two enabled ports target the same address, suppress the higher-numbered port and set conflict_error.
REQ-022 SHALL compute PC: update_pc -> new_pc; else if AUTO_INC=1 and no enabled port targets PC_INDEX -> pc+4 (mod 2^BIT_WIDTH, wrap); else regfile_update_pc=0.
REQ-023 SHALL, when update_pc=1 and any enabled port targets PC_INDEX, suppress those port writes, apply new_pc, and set conflict_error.
REQ-024 SHALL increment retired_count by 1 per pop (wrapping at 2^32); flushed entries are not counted.
REQ-025 SHALL on flush empty the FIFO at the edge, ignore a same-cycle push (in_ready=0 during flush), and not affect outputs already registered.
REQ-026 SHALL hold FIFO contents while stall=1; pushes continue until full.

Reset
REQ-027 SHALL on reset assertion immediately clear pointers, occupancy, retired_count, conflict_error, all regfile enables and regfile_update_pc; empty=1, in_ready=0 while reset asserted.
REQ-028 SHALL discard any entry mid-flight at reset; in_ready=1 first cycle after deassertion; data outputs (addr/value/new_pc) SHALL be 0 after reset.

Verification
REQ-029 Single entry pc=0x100, port0 r3<=0xDEAD, update_pc=0 -> one cycle later: write_enable=01, addr0=3, value0=0xDEAD, update_pc=1, new_pc=0x104, retired_count=1.
REQ-030 Branch-with-link: pc=0x200, new_pc=0x400, update_pc=1, port1 r14<=0x204 -> new_pc=0x400, r14 written, conflict_error=0.
REQ-031 Stall high, push DEPTH+1 entries -> in_ready=0 after 4th, no regfile enables; release stall -> 4 consecutive commit cycles in order, empty=1 after.
REQ-032 Port0 and port1 both r5, plus separate entry update_pc=1 with write to r15 -> only port0 written; r15 suppressed; conflict_error=1 and stays 1 until reset.
REQ-033 pc=0xFFFFFFFC, no writes, AUTO_INC=1 -> new_pc=0x00000000; AUTO_INC=0 -> regfile_update_pc=0.
REQ-034 3 entries buffered, flush with concurrent in_valid -> occupancy 0, push dropped, retired_count unchanged; async reset mid-stream -> outputs cleared without clock edge.
